// File: rtl/npu_pkg.sv
// Shared NPU definitions: default exponent type, its minimum value, and a
// constant-foldable ceil(log2) helper used to size count fields.
package npu_pkg;

  localparam int unsigned EXP_WIDTH_DEF = 8;

  typedef logic signed [EXP_WIDTH_DEF-1:0] exp_t;

  // Most negative representable exponent (-2^(EXP_WIDTH_DEF-1)).
  localparam exp_t EXP_MIN = exp_t'({1'b1, {(EXP_WIDTH_DEF-1){1'b0}}});

  // ceil(log2(v)), with clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned t;
    r = 0;
    t = 1;
    while (t < v) begin
      t = t << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/npu_lsd_count.sv
// Leading-sign-detect: counts redundant sign bits of a two's-complement operand.
// cnt is the left shift that makes bit[MSB] differ from bit[MSB-1]; an operand
// of all zeros or all ones yields A_WIDTH-1.
module npu_lsd_count
  import npu_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 16,
  localparam int unsigned CNT_WIDTH = clog2(A_WIDTH)
) (
  input  logic [A_WIDTH-1:0]   data,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 zero
);

  // Scan upward so the highest sign transition wins the final assignment.
  always_comb begin
    cnt  = CNT_WIDTH'(A_WIDTH - 1);
    zero = (data == '0);
    for (int i = 0; i < int'(A_WIDTH) - 1; i++) begin
      if (data[i+1] != data[i]) begin
        cnt = CNT_WIDTH'(int'(A_WIDTH) - i - 2);
      end
    end
  end

endmodule

// File: rtl/npu_sign_normalizer.sv
// Two-stage normaliser for signed fixed-point data.
// Stage 1 registers the operand together with its sign-bit count; stage 2
// registers the left-shifted mantissa and the saturated exponent debit.
// Valid/ready on both sides; in_ready is combinational through out_ready.
module npu_sign_normalizer
  import npu_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned EXP_WIDTH = 8,
  localparam int unsigned CNT_WIDTH = clog2(A_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   in_data,
  input  logic [EXP_WIDTH-1:0] in_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_WIDTH-1:0]   out_mant,
  output logic [CNT_WIDTH-1:0] out_cnt,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic                 out_zero,
  output logic                 out_uflow
);

  // Stage 1 state
  logic                 s1_valid;
  logic [A_WIDTH-1:0]   s1_data;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic [CNT_WIDTH-1:0] s1_cnt;
  logic                 s1_zero;

  // Stage 2 state (drives the outputs directly)
  logic                 s2_valid;
  logic [A_WIDTH-1:0]   s2_mant;
  logic [CNT_WIDTH-1:0] s2_cnt;
  logic [EXP_WIDTH-1:0] s2_exp;
  logic                 s2_zero;
  logic                 s2_uflow;

  // Combinational helpers
  logic                 s2_load;
  logic [CNT_WIDTH-1:0] lsd_cnt;
  logic                 lsd_zero;
  logic [A_WIDTH-1:0]   mant_next;
  logic [EXP_WIDTH:0]   exp_diff;
  logic [EXP_WIDTH-1:0] exp_next;
  logic                 uflow_next;

  npu_lsd_count #(
    .A_WIDTH (A_WIDTH)
  ) u_lsd (
    .data (in_data),
    .cnt  (lsd_cnt),
    .zero (lsd_zero)
  );

  // Handshake: stage 2 refills when empty or draining; stage 1 follows it.
  always_comb begin
    s2_load  = ~s2_valid | out_ready;
    in_ready = ~s1_valid | s2_load;
  end

  // Normalise: shift, then debit exponent with one guard bit to detect underflow.
  // The count is non-negative, so only the low end can saturate.
  always_comb begin
    mant_next  = s1_data << s1_cnt;
    exp_diff   = {s1_exp[EXP_WIDTH-1], s1_exp} - (EXP_WIDTH + 1)'(s1_cnt);
    exp_next   = exp_diff[EXP_WIDTH-1:0];
    uflow_next = 1'b0;
    if (s1_zero) begin
      exp_next = s1_exp;
    end else if (exp_diff[EXP_WIDTH] != exp_diff[EXP_WIDTH-1]) begin
      exp_next   = {1'b1, {(EXP_WIDTH-1){1'b0}}};
      uflow_next = 1'b1;
    end
  end

  // Stage 1 register: capture operand and its count whenever the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_exp   <= '0;
      s1_cnt   <= '0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_exp  <= in_exp;
        s1_cnt  <= lsd_cnt;
        s1_zero <= lsd_zero;
      end
    end
  end

  // Stage 2 register: holds steady while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mant  <= '0;
      s2_cnt   <= '0;
      s2_exp   <= '0;
      s2_zero  <= 1'b0;
      s2_uflow <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mant  <= mant_next;
        s2_cnt   <= s1_cnt;
        s2_exp   <= exp_next;
        s2_zero  <= s1_zero;
        s2_uflow <= uflow_next;
      end
    end
  end

  // Outputs straight from stage 2
  always_comb begin
    out_valid = s2_valid;
    out_mant  = s2_mant;
    out_cnt   = s2_cnt;
    out_exp   = s2_exp;
    out_zero  = s2_zero;
    out_uflow = s2_uflow;
  end

endmodule

// File: tb/tb_npu_sign_normalizer.sv
// Bench for npu_sign_normalizer (A_WIDTH=16, EXP_WIDTH=8): directed vector
// table with latency checks, stall burst, async reset flush, random traffic.
module tb_npu_sign_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_mant;
  logic [3:0]  out_cnt;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_uflow;

  always #5 clk = ~clk;

  npu_sign_normalizer #(
    .A_WIDTH   (16),
    .EXP_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_cnt   (out_cnt),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  typedef struct {
    logic [15:0] data;
    logic [7:0]  exp;
    logic [15:0] mant;
    logic [3:0]  cnt;
    logic [7:0]  exp_o;
    logic        zero;
    logic        uflow;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0] sb[$];
  logic        stall_prev = 1'b0;
  logic [30:0] held = '0;
  int          n_out = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: count bits below the MSB that repeat it, top down.
  function automatic logic [29:0] model(input logic [15:0] d, input logic [7:0] e);
    int          c;
    int          x;
    logic [15:0] m;
    logic [7:0]  eo;
    logic        z;
    logic        u;
    c = 0;
    for (int k = 14; k >= 0; k--) begin
      if (d[k] != d[15]) break;
      c++;
    end
    m = d << c;
    z = (d == 16'h0000);
    x = int'($signed(e)) - c;
    u = 1'b0;
    if (z) eo = e;
    else if (x < -128) begin
      eo = 8'h80;
      u  = 1'b1;
    end else eo = 8'(x);
    return {m, 4'(c), eo, z, u};
  endfunction

  function automatic logic [29:0] outs();
    return {out_mant, out_cnt, out_exp, out_zero, out_uflow};
  endfunction

  // One cycle of scoreboarded traffic; samples 1 time unit after the falling edge.
  task automatic step(input logic iv, input logic [15:0] d, input logic [7:0] e,
                      input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_exp    = e;
    out_ready = ordy;
    #1;
    if (stall_prev) check("stall_hold", 64'({out_valid, outs()}), 64'(held));
    if (ordy) check("ready_through", 64'(in_ready), 64'd1);
    acc = iv && in_ready;
    if (acc) sb.push_back(model(d, e));
    if (out_valid && ordy) begin
      n_out++;
      if (sb.size() == 0) check("extra_beat", 64'(outs()), 64'hDEAD);
      else check("result", 64'(outs()), 64'(sb.pop_front()));
    end
    stall_prev = out_valid && !ordy;
    held       = {out_valid, outs()};
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, '0, '0, 1'b1, acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  vec_t tbl[9];

  initial begin
    logic acc;
    int   nacc;
    int   cyc;
    int   seen_stall_acc;

    tbl[0] = '{16'h0003, 8'd0,    16'h6000, 4'd13, 8'hF3, 1'b0, 1'b0};
    tbl[1] = '{16'hFFF0, 8'd5,    16'h8000, 4'd11, 8'hFA, 1'b0, 1'b0};
    tbl[2] = '{16'hFFFF, 8'd0,    16'h8000, 4'd15, 8'hF1, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 8'd3,    16'h0000, 4'd15, 8'h03, 1'b1, 1'b0};
    tbl[4] = '{16'h4000, 8'd7,    16'h4000, 4'd0,  8'h07, 1'b0, 1'b0};
    tbl[5] = '{16'h0001, 8'h88,   16'h4000, 4'd14, 8'h80, 1'b0, 1'b1};
    tbl[6] = '{16'h0001, 8'h8E,   16'h4000, 4'd14, 8'h80, 1'b0, 1'b0};
    tbl[7] = '{16'h8000, 8'd0,    16'h8000, 4'd0,  8'h00, 1'b0, 1'b0};
    tbl[8] = '{16'hC000, 8'hFF,   16'h8000, 4'd1,  8'hFE, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_mant", 64'(out_mant), 64'd0);

    // Directed table, one beat at a time, with two-edge latency
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = tbl[i].data; in_exp = tbl[i].exp; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("lat_edge1", 64'(out_valid), 64'd0);
      @(negedge clk);
      #1;
      check("lat_edge2", 64'(out_valid), 64'd1);
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({tbl[i].mant, tbl[i].cnt, tbl[i].exp_o, tbl[i].zero, tbl[i].uflow}));
    end
    @(negedge clk);

    // Burst of 8 with a 5-cycle downstream stall in the middle
    nacc = 0;
    seen_stall_acc = 0;
    for (cyc = 0; cyc < 40 && nacc < 8; cyc++) begin
      logic r;
      r = !(cyc >= 3 && cyc < 8);
      step(1'b1, 16'(16'h0013 << nacc), 8'(nacc), r, acc);
      if (acc) nacc++;
      if (!r && acc) seen_stall_acc++;
      if (cyc >= 5 && cyc < 8) check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    check("burst_accepted", 64'(nacc), 64'd8);
    check("stall_accepts_le2", 64'(seen_stall_acc <= 2), 64'd1);
    drain();

    // Async reset with both stages full
    step(1'b1, 16'h0007, 8'd1, 1'b0, acc);
    step(1'b1, 16'hFF00, 8'd2, 1'b0, acc);
    step(1'b0, '0, '0, 1'b0, acc);
    check("pre_rst_full", 64'({out_valid, in_ready}), 64'b10);
    rst_n = 1'b0;
    #1;
    check("async_clear", 64'(out_valid), 64'd0);
    sb.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, acc);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    step(1'b1, 16'h0100, 8'd0, 1'b1, acc);
    drain();

    // Random valid/ready traffic against the model
    nacc  = 0;
    n_out = 0;
    for (cyc = 0; cyc < 40000 && nacc < 10000; cyc++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), acc);
      if (acc) nacc++;
    end
    check("random_accepted", 64'(nacc), 64'd10000);
    drain();
    check("random_no_loss", 64'(n_out), 64'(nacc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
